// File: rtl/shot_sequencer.sv
// shot_sequencer: turns a fire-button press into one timed shockwave shot.
// A rising edge on fire_btn in IDLE latches the aim direction and spread,
// holds fire high for FIRE_FRAMES video frames, then waits out a cooldown
// of (4 - shoot_mode) * COOL_BASE frames before returning to IDLE.
//
// Optional feature (macro SHOT_SEQUENCER_AMMO_EN): wide-spread (mode 1) shots
// consume ammo, are refused at zero ammo, and ammo_reload refills the store.
// With the macro undefined, mode 1 is unlimited and ammo reads AMMO_MAX.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   fire_btn     debounced button level (synchronous to clk)
//   frame_tick   one-cycle pulse per video frame
//   angle_in     aim direction 0..15
//   mode_sel     requested spread (1 = five rays, 2 = three, 3 = one, 0 = none)
//   ammo_reload  one-cycle pulse refilling mode-1 ammo
//   fire         shockwave renderer enable
//   hit_angle    latched shot direction
//   shoot_mode   latched spread
//   busy         high whenever the sequencer is not IDLE
//   shot_done    one-cycle pulse on return to IDLE
//   ammo         remaining mode-1 shots
module shot_sequencer #(
  parameter int unsigned FIRE_FRAMES = 15,
  parameter int unsigned COOL_BASE   = 10,
  parameter int unsigned AMMO_MAX    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire_btn,
  input  logic       frame_tick,
  input  logic [3:0] angle_in,
  input  logic [1:0] mode_sel,
  input  logic       ammo_reload,
  output logic       fire,
  output logic [3:0] hit_angle,
  output logic [1:0] shoot_mode,
  output logic       busy,
  output logic       shot_done,
  output logic [2:0] ammo
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ANGLE_W = 4;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned AMMO_W  = 3;

  localparam logic [CNT_W-1:0]  FIRE_LEN  = CNT_W'(FIRE_FRAMES);
  localparam logic [CNT_W-1:0]  COOL_UNIT = CNT_W'(COOL_BASE);
  localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 btn_d;
  logic                 fire_nxt;
  logic [ANGLE_W-1:0]   angle_nxt;
  logic [MODE_W-1:0]    mode_nxt;
  logic                 done_nxt;
  logic                 busy_nxt;
  logic [AMMO_W-1:0]    ammo_nxt;

  logic                 press;
  logic                 mode_ok;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CNT_W-1:0]     cool_len;

  // Rising edge of the button; btn_d resets high so a held button is ignored.
  assign press   = fire_btn & ~btn_d;
  assign cnt_inc = CNT_W'(cnt + CNT_W'(1));

  // Cooldown frames for the latched spread, 8-bit arithmetic.
  assign cool_len = CNT_W'((CNT_W'(4) - CNT_W'(shoot_mode)) * COOL_UNIT);

`ifdef SHOT_SEQUENCER_AMMO_EN
  assign mode_ok = (mode_sel != MODE_W'(0)) &&
                   !((mode_sel == MODE_W'(1)) && (ammo == AMMO_W'(0)));
`else
  assign mode_ok = (mode_sel != MODE_W'(0));
  logic unused_reload;
  assign unused_reload = ammo_reload;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire_nxt  = fire;
    angle_nxt = hit_angle;
    mode_nxt  = shoot_mode;
    done_nxt  = 1'b0;
    ammo_nxt  = ammo;

    case (state)
      IDLE: begin
        // frame_tick is not looked at here, so a coincident tick is not counted.
        if (press && mode_ok) begin
          state_nxt = FIRE;
          cnt_nxt   = '0;
          fire_nxt  = 1'b1;
          angle_nxt = angle_in;
          mode_nxt  = mode_sel;
`ifdef SHOT_SEQUENCER_AMMO_EN
          if (mode_sel == MODE_W'(1)) begin
            ammo_nxt = AMMO_W'(ammo - AMMO_W'(1));
          end
`endif
        end
      end
      FIRE: begin
        if (frame_tick) begin
          if (cnt_inc == FIRE_LEN) begin
            state_nxt = COOLDOWN;
            cnt_nxt   = '0;
            fire_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cnt_inc == cool_len) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        fire_nxt  = 1'b0;
      end
    endcase

`ifdef SHOT_SEQUENCER_AMMO_EN
    // Reload overrides a same-cycle mode-1 decrement.
    if (ammo_reload) begin
      ammo_nxt = AMMO_FULL;
    end
`else
    ammo_nxt = AMMO_FULL;
`endif

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      btn_d      <= 1'b1;
      fire       <= 1'b0;
      hit_angle  <= '0;
      shoot_mode <= '0;
      busy       <= 1'b0;
      shot_done  <= 1'b0;
      ammo       <= AMMO_FULL;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      btn_d      <= fire_btn;
      fire       <= fire_nxt;
      hit_angle  <= angle_nxt;
      shoot_mode <= mode_nxt;
      busy       <= busy_nxt;
      shot_done  <= done_nxt;
      ammo       <= ammo_nxt;
    end
  end

endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer. Each accepted press pushes the
// expected shot (angle, spread, fire frames, cooldown frames) into a queue;
// the record is popped and compared once the shot has been observed.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_shot_sequencer;

  localparam int unsigned FIRE_FRAMES = 15;
  localparam int unsigned COOL_BASE   = 10;
  localparam int unsigned AMMO_MAX    = 3;
`ifdef SHOT_SEQUENCER_AMMO_EN
  localparam bit AMMO_ON = 1'b1;
`else
  localparam bit AMMO_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0] angle;
    logic [1:0] mode;
    int         fire_ticks;
    int         cool_ticks;
  } shot_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fire_btn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] angle_in = '0;
  logic [1:0] mode_sel = '0;
  logic       ammo_reload = 1'b0;
  logic       fire;
  logic [3:0] hit_angle;
  logic [1:0] shoot_mode;
  logic       busy;
  logic       shot_done;
  logic [2:0] ammo;

  shot_t exp_q[$];
  int checks = 0;
  int passed = 0;

  shot_sequencer #(
    .FIRE_FRAMES(FIRE_FRAMES),
    .COOL_BASE  (COOL_BASE),
    .AMMO_MAX   (AMMO_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fire_btn   (fire_btn),
    .frame_tick (frame_tick),
    .angle_in   (angle_in),
    .mode_sel   (mode_sel),
    .ammo_reload(ammo_reload),
    .fire       (fire),
    .hit_angle  (hit_angle),
    .shoot_mode (shoot_mode),
    .busy       (busy),
    .shot_done  (shot_done),
    .ammo       (ammo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; fire_btn = 1'b0; frame_tick = 1'b0; ammo_reload = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic press(input logic [3:0] a, input logic [1:0] m, input bit tick,
                       input bit reload, input bit hold);
    fire_btn = 1'b0;
    step();
    angle_in = a; mode_sel = m; fire_btn = 1'b1; frame_tick = tick; ammo_reload = reload;
    step();
    frame_tick = 1'b0; ammo_reload = 1'b0;
    if (!hold) fire_btn = 1'b0;
  endtask

  function automatic shot_t make_exp(input logic [3:0] a, input logic [1:0] m);
    shot_t s;
    s.angle      = a;
    s.mode       = m;
    s.fire_ticks = int'(FIRE_FRAMES);
    s.cool_ticks = (4 - int'(m)) * int'(COOL_BASE);
    return s;
  endfunction

  // Observes one shot from just after its press until shot_done; no checking.
  task automatic measure_shot(input int new_angle, input bit press_cool,
                              output shot_t obs, output int dones,
                              output bit stable, output bit timeout);
    bit got;
    obs.angle = hit_angle; obs.mode = shoot_mode;
    obs.fire_ticks = 0; obs.cool_ticks = 0;
    dones = 0; stable = 1'b1; timeout = 1'b0; got = 1'b0;
    for (int i = 0; i < 400 && fire === 1'b1; i++) begin
      if (i == 3 && new_angle >= 0) begin
        angle_in = 4'(new_angle);
        mode_sel = 2'd0;
      end
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      obs.fire_ticks++;
      if (hit_angle !== obs.angle || shoot_mode !== obs.mode) stable = 1'b0;
      step();
    end
    if (fire !== 1'b0) timeout = 1'b1;
    for (int i = 0; i < 400 && !timeout; i++) begin
      if (press_cool && i == 5) begin
        fire_btn = 1'b0; step(); fire_btn = 1'b1; step();
      end
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      obs.cool_ticks++;
      if (hit_angle !== obs.angle || shoot_mode !== obs.mode) stable = 1'b0;
      if (shot_done === 1'b1) begin
        dones = 1;
        step();
        if (shot_done === 1'b1) dones++;
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fire_btn = 1'b1; mode_sel = 2'd3; angle_in = 4'd6;
    step(); step();
    checks++; if (fire !== 1'b0) $display("FAIL reset_fire: got %0b expected 0", fire); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
    checks++; if (hit_angle !== 4'd0) $display("FAIL reset_angle: got %0d expected 0", hit_angle); else passed++;
    checks++; if (shoot_mode !== 2'd0) $display("FAIL reset_mode: got %0d expected 0", shoot_mode); else passed++;
    checks++; if (shot_done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", shot_done); else passed++;
    checks++; if (ammo !== 3'(AMMO_MAX)) $display("FAIL reset_ammo: got %0d expected %0d", ammo, AMMO_MAX); else passed++;
    rst = 1'b0;
    step(); step();
    checks++; if (busy !== 1'b0) $display("FAIL reset_held_btn_busy: got %0b expected 0", busy); else passed++;
    fire_btn = 1'b0;
    step();
  endtask

  task automatic test_basic();
    shot_t obs, e;
    int dones; bit stable, to;
    do_reset();
    exp_q.push_back(make_exp(4'd5, 2'd2));
    press(4'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (fire !== 1'b1) $display("FAIL basic_fire_on: got %0b expected 1", fire); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %0b expected 1", busy); else passed++;
    measure_shot(-1, 1'b0, obs, dones, stable, to);
    e = exp_q.pop_front();
    checks++; if (to) $display("FAIL basic_timeout: got timeout expected shot_done"); else passed++;
    checks++; if (obs.angle !== e.angle) $display("FAIL basic_angle: got %0d expected %0d", obs.angle, e.angle); else passed++;
    checks++; if (obs.mode !== e.mode) $display("FAIL basic_mode: got %0d expected %0d", obs.mode, e.mode); else passed++;
    checks++; if (obs.fire_ticks != e.fire_ticks) $display("FAIL basic_fire_ticks: got %0d expected %0d", obs.fire_ticks, e.fire_ticks); else passed++;
    checks++; if (obs.cool_ticks != e.cool_ticks) $display("FAIL basic_cool_ticks: got %0d expected %0d", obs.cool_ticks, e.cool_ticks); else passed++;
    checks++; if (dones != 1) $display("FAIL basic_done_pulse: got %0d cycles expected 1", dones); else passed++;
    checks++; if (!stable) $display("FAIL basic_stable: got changing outputs expected held"); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %0b expected 0", busy); else passed++;
  endtask

  task automatic test_hold();
    shot_t obs, e;
    int dones; bit stable, to, extra;
    do_reset();
    exp_q.push_back(make_exp(4'd7, 2'd3));
    press(4'd7, 2'd3, 1'b0, 1'b0, 1'b1);
    measure_shot(-1, 1'b0, obs, dones, stable, to);
    e = exp_q.pop_front();
    checks++; if (obs.fire_ticks != e.fire_ticks) $display("FAIL hold_fire_ticks: got %0d expected %0d", obs.fire_ticks, e.fire_ticks); else passed++;
    checks++; if (obs.cool_ticks != e.cool_ticks) $display("FAIL hold_cool_ticks: got %0d expected %0d", obs.cool_ticks, e.cool_ticks); else passed++;
    extra = 1'b0;
    for (int f = obs.fire_ticks + obs.cool_ticks; f < 100; f++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      if (busy !== 1'b0 || fire !== 1'b0) extra = 1'b1;
      step();
    end
    checks++; if (extra) $display("FAIL hold_single_shot: got extra shot expected none"); else passed++;
    fire_btn = 1'b0;
    step();
  endtask

  task automatic test_mode0();
    bit seen;
    do_reset();
    press(4'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || fire !== 1'b0) seen = 1'b1;
      step();
    end
    checks++; if (seen) $display("FAIL mode0_ignored: got busy/fire expected idle"); else passed++;
  endtask

  task automatic test_ammo();
    shot_t obs, e;
    int dones, exp_ammo; bit stable, to, accept;
    do_reset();
    exp_ammo = int'(AMMO_MAX);
    for (int k = 0; k < 4; k++) begin
      checks++; if (ammo !== 3'(exp_ammo)) $display("FAIL ammo_before_%0d: got %0d expected %0d", k, ammo, exp_ammo); else passed++;
      accept = !AMMO_ON || exp_ammo > 0;
      if (accept) exp_q.push_back(make_exp(4'(k), 2'd1));
      press(4'(k), 2'd1, 1'b0, 1'b0, 1'b0);
      if (accept && AMMO_ON) exp_ammo--;
      checks++; if (busy !== accept) $display("FAIL ammo_accept_%0d: got %0b expected %0b", k, busy, accept); else passed++;
      checks++; if (ammo !== 3'(exp_ammo)) $display("FAIL ammo_after_%0d: got %0d expected %0d", k, ammo, exp_ammo); else passed++;
      if (busy === 1'b1) begin
        measure_shot(-1, 1'b0, obs, dones, stable, to);
        if (accept) begin
          e = exp_q.pop_front();
          checks++; if (obs.cool_ticks != e.cool_ticks) $display("FAIL ammo_cool_%0d: got %0d expected %0d", k, obs.cool_ticks, e.cool_ticks); else passed++;
        end
      end
    end
    ammo_reload = 1'b1; step(); ammo_reload = 1'b0;
    checks++; if (ammo !== 3'(AMMO_MAX)) $display("FAIL ammo_reload: got %0d expected %0d", ammo, AMMO_MAX); else passed++;
    exp_ammo = AMMO_ON ? int'(AMMO_MAX) - 1 : int'(AMMO_MAX);
    press(4'd8, 2'd1, 1'b0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) $display("FAIL ammo_refire: got %0b expected 1", busy); else passed++;
    checks++; if (ammo !== 3'(exp_ammo)) $display("FAIL ammo_refire_count: got %0d expected %0d", ammo, exp_ammo); else passed++;
    measure_shot(-1, 1'b0, obs, dones, stable, to);
    // A reload coinciding with a mode-1 acceptance leaves the store full.
    press(4'd9, 2'd1, 1'b0, 1'b1, 1'b0);
    checks++; if (busy !== 1'b1) $display("FAIL ammo_reload_win_busy: got %0b expected 1", busy); else passed++;
    checks++; if (ammo !== 3'(AMMO_MAX)) $display("FAIL ammo_reload_win: got %0d expected %0d", ammo, AMMO_MAX); else passed++;
    measure_shot(-1, 1'b0, obs, dones, stable, to);
  endtask

  task automatic test_angle_lock();
    shot_t obs, e;
    int dones; bit stable, to, seen;
    do_reset();
    exp_q.push_back(make_exp(4'd2, 2'd2));
    press(4'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    measure_shot(9, 1'b1, obs, dones, stable, to);
    e = exp_q.pop_front();
    checks++; if (obs.angle !== e.angle) $display("FAIL lock_angle: got %0d expected %0d", obs.angle, e.angle); else passed++;
    checks++; if (!stable) $display("FAIL lock_stable: got changing outputs expected held"); else passed++;
    checks++; if (obs.cool_ticks != e.cool_ticks) $display("FAIL lock_cool_ticks: got %0d expected %0d", obs.cool_ticks, e.cool_ticks); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0 || fire !== 1'b0) seen = 1'b1;
      step();
    end
    checks++; if (seen) $display("FAIL lock_no_queue: got second shot expected none"); else passed++;
    fire_btn = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    press(4'd4, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    end
    frame_tick = 1'b1; rst = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++; if (fire !== 1'b0) $display("FAIL rstmid_fire: got %0b expected 0", fire); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b expected 0", busy); else passed++;
    checks++; if (ammo !== 3'(AMMO_MAX)) $display("FAIL rstmid_ammo: got %0d expected %0d", ammo, AMMO_MAX); else passed++;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      if (shot_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    checks++; if (seen) $display("FAIL rstmid_no_done: got activity expected none"); else passed++;
  endtask

  task automatic test_tick_on_press();
    shot_t obs, e;
    int dones; bit stable, to;
    do_reset();
    exp_q.push_back(make_exp(4'd15, 2'd3));
    press(4'd15, 2'd3, 1'b1, 1'b0, 1'b0);
    measure_shot(-1, 1'b0, obs, dones, stable, to);
    e = exp_q.pop_front();
    checks++; if (obs.fire_ticks != e.fire_ticks) $display("FAIL tickpress_fire_ticks: got %0d expected %0d", obs.fire_ticks, e.fire_ticks); else passed++;
    checks++; if (obs.angle !== e.angle) $display("FAIL tickpress_angle: got %0d expected %0d", obs.angle, e.angle); else passed++;
    // Back-to-back: a press right after shot_done is accepted.
    press(4'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) $display("FAIL back_to_back: got %0b expected 1", busy); else passed++;
    measure_shot(-1, 1'b0, obs, dones, stable, to);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_mode0();
    test_ammo();
    test_angle_lock();
    test_reset_mid();
    test_tick_on_press();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shot_sequencer.md
SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter FIRE_FRAMES, default 15: number of frame_tick pulses during which the shockwave is displayed (1..255).
REQ-002 Parameter COOL_BASE, default 10: cooldown unit in frames (1..85).
REQ-003 Parameter AMMO_MAX, default 3: wide-spread (mode 1) shot capacity (1..7).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 fire_btn  input  1  debounced fire button level, synchronous to clk.
REQ-007 frame_tick  input  1  single-cycle pulse once per video frame.
REQ-008 angle_in  input  4  current aim direction, 0..15.
REQ-009 mode_sel  input  2  requested spread: 1 = five rays, 2 = three rays, 3 = single ray, 0 = none.
REQ-010 ammo_reload  input  1  single-cycle pulse that refills mode-1 ammo.
REQ-011 fire  output  1  drives the shockwave renderer enable.
REQ-012 hit_angle  output  4  latched shot direction for the renderer.
REQ-013 shoot_mode  output  2  latched spread for the renderer.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 shot_done  output  1  single-cycle pulse on return to IDLE.
REQ-016 ammo  output  3  remaining mode-1 shots.

Function
REQ-017 The block SHALL detect a press as fire_btn high while its one-cycle-delayed copy is low; holding the button SHALL produce only one press.
REQ-018 States SHALL be IDLE, FIRE and COOLDOWN; a frame counter (8 bits) SHALL be cleared on every state entry.
REQ-019 In IDLE, a press with mode_sel != 0 SHALL move to FIRE on the next edge, latching hit_angle = angle_in and shoot_mode = mode_sel and setting fire = 1 in that same edge.
REQ-020 A press with mode_sel == 0, or with mode_sel == 1 and ammo == 0, SHALL be ignored and the block SHALL remain in IDLE.
REQ-021 Accepting a mode-1 shot SHALL decrement ammo by 1 in the same edge as entry to FIRE.
REQ-022 In FIRE, the counter SHALL increment on each frame_tick; the frame_tick that brings the count to FIRE_FRAMES SHALL move the block to COOLDOWN with fire = 0.
REQ-023 Cooldown length SHALL be (4 - shoot_mode) * COOL_BASE frames: 3x for mode 1, 2x for mode 2, 1x for mode 3, computed at 8-bit width.
REQ-024 In COOLDOWN, the frame_tick that completes the cooldown length SHALL return the block to IDLE and assert shot_done for exactly that next cycle.
REQ-025 Presses during FIRE or COOLDOWN SHALL be discarded, not queued.
REQ-026 hit_angle and shoot_mode SHALL hold their latched values through FIRE and COOLDOWN regardless of changes on angle_in or mode_sel.
REQ-027 A frame_tick coincident with an accepted press in IDLE SHALL NOT be counted toward FIRE.
REQ-028 ammo_reload SHALL set ammo = AMMO_MAX in any state; if it coincides with a mode-1 decrement, reload SHALL win.

Reset
REQ-029 While rst is high, on each clk edge the block SHALL set: state = IDLE, counter = 0, fire = 0, hit_angle = 0, shoot_mode = 0, shot_done = 0, ammo = AMMO_MAX, and the delayed button copy = 1 (so a button held through reset does not fire).
REQ-030 Reset asserted mid-FIRE or mid-COOLDOWN SHALL abort the shot on the next edge without asserting shot_done.

Configuration
REQ-031 Macro SHOT_SEQUENCER_AMMO_EN: when it is defined, REQ-020 (ammo == 0 check), REQ-021 and REQ-028 apply.
REQ-032 When the macro is not defined, mode-1 shots SHALL be unlimited, ammo SHALL be held at AMMO_MAX, ammo_reload SHALL be ignored, and all ports SHALL remain present.

Verification
REQ-033 Press with angle_in = 5, mode_sel = 2, then FIRE_FRAMES = 15 ticks -> fire high for exactly 15 ticks; hit_angle = 5 and shoot_mode = 2 throughout; COOLDOWN lasts 20 ticks; then one shot_done pulse.
REQ-034 Hold fire_btn high for 100 frames with mode_sel = 3 -> exactly one shot, with cooldown of 10 ticks.
REQ-035 With the macro defined, four mode-1 presses each spaced after shot_done -> ammo goes 3, 2, 1, 0 and the fourth press is ignored; an ammo_reload pulse -> ammo = 3 and the next press fires.
REQ-036 Change angle_in from 2 to 9 during FIRE, and press during COOLDOWN -> hit_angle stays 2; no second shot occurs.
REQ-037 Assert rst at the 7th tick of FIRE -> next edge fire = 0 and busy = 0; shot_done never pulses; ammo = AMMO_MAX.
REQ-038 Press with mode_sel = 0 -> busy stays 0 and fire stays 0.
